pattern_detector: RTL and testbench

Parametrised serial pattern detector: samples a 1-bit stream qualified by `valid_in`, compares the last `PATTERN_LEN` accepted bits against a configurable pattern, and emits a one-cycle registered `match` pulse. Generalises the fixed single-input sequence FSMs used in the lab exercises to arbitrary pattern width and value. Adds overlap or non-overlap mode, a fill guard against false matches at start-up, a synchronous clear and an optional saturating match counter. Sits directly behind a serial input synchroniser and feeds status or interrupt logic.

---
 rtl/pattern_detector_pkg.sv | 19 +
 rtl/pattern_detector_if.sv | 22 ++
 rtl/pattern_detector_sat_counter.sv | 36 +++
 rtl/pattern_detector.sv | 104 ++++++++++
 tb/tb_pattern_detector.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_detector_pkg.sv
// Shared types and defaults for the serial pattern detector.
package pattern_det_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } det_state_t;

    localparam int          DEF_PATTERN_LEN = 4;
    localparam logic [31:0] DEF_PATTERN     = 32'h0000_000B;
    localparam bit          DEF_OVERLAP     = 1'b1;
    localparam int          DEF_COUNT_W     = 8;

    // Width of the fill counter, which must be able to hold the value len.
    function automatic int FILL_W(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/pattern_detector_if.sv
// Stream input and status output bundle of the pattern detector.
interface pattern_detector_if #(
    parameter int COUNT_W = 8
);
    logic               valid_in;
    logic               data_in;
    logic               clear;
    logic               match;
    logic               armed;
    logic [COUNT_W-1:0] match_count;
    logic               count_sat;

    modport master (
        output valid_in, data_in, clear,
        input  match, armed, match_count, count_sat
    );

    modport slave (
        input  valid_in, data_in, clear,
        output match, armed, match_count, count_sat
    );
endinterface

// File: rtl/pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         sat
);
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next count: clear first, otherwise step unless already at maximum.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && !(&q_q)) begin
            q_d = q_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q   = q_q;
    assign sat = &q_q;
endmodule

// File: rtl/pattern_detector.sv
// Serial pattern detector: shift history, fill guard, FILL/ARMED FSM,
// compare and registered match pulse. The optional saturating match
// counter is built only when PATTERN_DET_COUNT_EN is defined.
//
//   state | meaning
//   FILL  | fewer than PATTERN_LEN bits held since reset/clear/restart
//   ARMED | history full, every accepted bit is compared
module pattern_detector
    import pattern_det_pkg::*;
#(
    parameter int                     PATTERN_LEN = DEF_PATTERN_LEN,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = PATTERN_LEN'(DEF_PATTERN),
    parameter bit                     OVERLAP     = DEF_OVERLAP,
    parameter int                     COUNT_W     = DEF_COUNT_W
) (
    input  logic              clk,
    input  logic              reset,
    pattern_detector_if.slave bus
);
    localparam int            FW        = FILL_W(PATTERN_LEN);
    localparam logic [FW-1:0] FILL_LAST = FW'(PATTERN_LEN - 1);

    det_state_t             state_q, state_d;
    logic [PATTERN_LEN-1:0] hist_q, hist_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic                   match_q, match_d;
    logic                   armed_q;
    logic [PATTERN_LEN-1:0] shifted;
    logic                   completes;

    // Next-state: clear dominates; an accepted bit shifts, fills and compares.
    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = 1'b0;
        shifted   = {hist_q[PATTERN_LEN-2:0], bus.data_in};
        // A compare is only legal once the history holds PATTERN_LEN real bits,
        // which keeps reset zeros from matching an all-zero pattern.
        completes = (state_q == ARMED) || (fill_q == FILL_LAST);
        if (bus.clear) begin
            hist_d  = '0;
            fill_d  = '0;
            state_d = FILL;
        end else if (bus.valid_in) begin
            match_d = completes && (shifted == PATTERN);
            if (match_d && (OVERLAP == 1'b0)) begin
                hist_d  = '0;
                fill_d  = '0;
                state_d = FILL;
            end else begin
                hist_d = shifted;
                if (state_q == FILL) begin
                    fill_d = fill_q + FW'(1);
                    if (fill_q == FILL_LAST) begin
                        state_d = ARMED;
                    end
                end
            end
        end
    end

    // State, history, fill and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            armed_q <= (state_d == ARMED);
        end
    end

    assign bus.match = match_q;
    assign bus.armed = armed_q;

`ifdef PATTERN_DET_COUNT_EN
    logic [COUNT_W-1:0] cnt_q;
    logic               cnt_sat;

    sat_counter #(
        .W (COUNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clear),
        .inc   (match_d),
        .q     (cnt_q),
        .sat   (cnt_sat)
    );

    assign bus.match_count = cnt_q;
    assign bus.count_sat   = cnt_sat;
`else
    assign bus.match_count = '0;
    assign bus.count_sat   = 1'b0;
`endif
endmodule

// File: tb/tb_pattern_detector.sv
// Bench for pattern_detector: three instances (1011 overlap, 1011 no-overlap
// with 2-bit counter, 0000 overlap with 2-bit counter) share one stimulus
// stream and are checked each cycle against a bit-history model.
module tb_pattern_detector;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vld = 1'b0;
    logic dat = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    pattern_detector_if #(.COUNT_W(8)) if_a ();
    pattern_detector_if #(.COUNT_W(2)) if_b ();
    pattern_detector_if #(.COUNT_W(2)) if_c ();

    assign if_a.valid_in = vld;  assign if_a.data_in = dat;  assign if_a.clear = clr;
    assign if_b.valid_in = vld;  assign if_b.data_in = dat;  assign if_b.clear = clr;
    assign if_c.valid_in = vld;  assign if_c.data_in = dat;  assign if_c.clear = clr;

    pattern_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .COUNT_W(8))
        dut_a (.clk(clk), .reset(rst), .bus(if_a));
    pattern_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .COUNT_W(2))
        dut_b (.clk(clk), .reset(rst), .bus(if_b));
    pattern_detector #(.PATTERN_LEN(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .COUNT_W(2))
        dut_c (.clk(clk), .reset(rst), .bus(if_c));

    wire [2:0] mo = {if_c.match, if_b.match, if_a.match};
    wire [2:0] ao = {if_c.armed, if_b.armed, if_a.armed};
    wire [2:0] so = {if_c.count_sat, if_b.count_sat, if_a.count_sat};

    int checks   = 0;
    int failures = 0;

    // Model: value of the last accepted bits and how many have been held
    // since the last restart, plus expected match pulse and match count.
    int pat  [3] = '{11, 11, 0};
    bit ovl  [3] = '{1'b1, 1'b0, 1'b1};
    int cmax [3] = '{255, 3, 3};
    int hv   [3];
    int hn   [3];
    int cnt  [3];
    bit me   [3];
    int pulses [3];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int cnt_of(input int i);
        if (i == 0) return int'(if_a.match_count);
        if (i == 1) return int'(if_b.match_count);
        return int'(if_c.match_count);
    endfunction

    function automatic int exp_cnt(input int i);
`ifdef PATTERN_DET_COUNT_EN
        return cnt[i];
`else
        return 0;
`endif
    endfunction

    function automatic int exp_sat(input int i);
`ifdef PATTERN_DET_COUNT_EN
        return (cnt[i] == cmax[i]) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hv[i] = 0; hn[i] = 0; cnt[i] = 0; me[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (clr) begin
                hv[i] = 0; hn[i] = 0; cnt[i] = 0; me[i] = 1'b0;
            end else if (vld) begin
                hv[i] = ((hv[i] * 2) + int'(dat)) % 16;
                if (hn[i] < 4) hn[i]++;
                me[i] = (hn[i] == 4) && (hv[i] == pat[i]);
                if (me[i]) begin
                    if (cnt[i] < cmax[i]) cnt[i]++;
                    if (!ovl[i]) begin hv[i] = 0; hn[i] = 0; end
                end
            end else begin
                me[i] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("match[%0d]", i), int'(mo[i]), int'(me[i]));
            chk($sformatf("armed[%0d]", i), int'(ao[i]), (hn[i] == 4) ? 1 : 0);
            chk($sformatf("count[%0d]", i), cnt_of(i), exp_cnt(i));
            chk($sformatf("sat[%0d]", i), int'(so[i]), exp_sat(i));
            pulses[i] += int'(mo[i]);
        end
    endtask

    // One clock: model sees the same inputs the DUT samples, compare on negedge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        vld = 1'b0; clr = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send(input logic [31:0] bits, input int n);
        logic [31:0] b;
        b = bits;
        for (int k = n - 1; k >= 0; k--) begin
            vld = 1'b1; dat = b[k]; clr = 1'b0;
            tick();
        end
        vld = 1'b0;
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic pulse_reset();
        #1 rst = 1'b1;
        model_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_match_a", int'(if_a.match), 0);
        chk("rst_armed_a", int'(if_a.armed), 0);
        chk("rst_count_a", int'(if_a.match_count), 0);
        chk("rst_sat_b",   int'(if_b.count_sat), 0);
    endtask

    int base [3];

    task automatic snap();
        for (int i = 0; i < 3; i++) base[i] = pulses[i];
    endtask

    function automatic int got(input int i);
        return pulses[i] - base[i];
    endfunction

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) pulses[i] = 0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_match_a", int'(if_a.match), 0);
        chk("rst_armed_a", int'(if_a.armed), 0);

        // 1011 after reset: one pulse, armed, count 1.
        snap();
        send(32'b1011, 4);
        chk("t1_match_now", int'(if_a.match), 1);
        chk("t1_armed", int'(if_a.armed), 1);
`ifdef PATTERN_DET_COUNT_EN
        chk("t1_count", int'(if_a.match_count), 1);
`else
        chk("t1_count", int'(if_a.match_count), 0);
`endif
        idle(1);
        chk("t1_match_gone", int'(if_a.match), 0);
        chk("t1_pulses_a", got(0), 1);
        chk("t1_pulses_c", got(2), 0);

        // 1011011: two overlapping matches, one without overlap.
        pulse_reset();
        snap();
        send(32'b1011011, 7);
        chk("t2_pulses_ovl", got(0), 2);
        chk("t3_pulses_noovl_a", got(1), 1);

        // 10111011 without overlap: two matches.
        pulse_reset();
        snap();
        send(32'b10111011, 8);
        chk("t3_pulses_noovl_b", got(1), 2);

        // All-zero pattern fill guard.
        pulse_reset();
        snap();
        send(32'b000, 3);
        chk("t4_no_early", got(2), 0);
        chk("t4_armed0", int'(if_c.armed), 0);
        send(32'b0, 1);
        chk("t4_fourth", got(2), 1);
        send(32'b0, 1);
        chk("t4_fifth", got(2), 2);

        // Gaps in valid_in hold the history.
        pulse_reset();
        snap();
        send(32'b10, 2);
        idle(3);
        send(32'b11, 2);
        chk("t5_gap_match", got(0), 1);

        // Reset mid-pattern discards history.
        pulse_reset();
        snap();
        send(32'b101, 3);
        pulse_reset();
        send(32'b1, 1);
        chk("t6_rst_mid", got(0), 0);
        chk("t6_rst_count", int'(if_a.match_count), 0);

        // Clear on the completing bit suppresses the match.
        pulse_reset();
        snap();
        send(32'b101, 3);
        vld = 1'b1; dat = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0; vld = 1'b0;
        idle(1);
        chk("t6_clr_match", got(0), 0);
        chk("t6_clr_armed", int'(if_a.armed), 0);

        // Five matches into a 2-bit saturating counter.
        pulse_reset();
        snap();
        for (int r = 0; r < 5; r++) send(32'b1011, 4);
        chk("t7_pulses_b", got(1), 5);
`ifdef PATTERN_DET_COUNT_EN
        chk("t7_count_b", int'(if_b.match_count), 3);
        chk("t7_sat_b", int'(if_b.count_sat), 1);
`else
        chk("t7_count_b", int'(if_b.match_count), 0);
        chk("t7_sat_b", int'(if_b.count_sat), 0);
`endif

        // Random traffic with occasional clears and resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                pulse_reset();
            end
            vld = ($urandom_range(0, 3) != 0);
            dat = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 59) == 0);
            tick();
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
